// File: rtl/riscv_pkg.sv
// Shared RV32I ALU-issue types: command enum, opcode/funct constants and the issue record.
package riscv_pkg;

  localparam int ISSUE_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_cmd_t               cmd;
    logic [ISSUE_XLEN-1:0]  a;
    logic [ISSUE_XLEN-1:0]  b;
    logic [4:0]             rd;
    logic                   we;
    logic                   illegal;
  } alu_issue_t;

  // alt selects SUB over ADD and SRA over SRL; ignored for other funct3 values
  function automatic alu_cmd_t f3_cmd(input logic [2:0] f3, input logic alt);
    alu_cmd_t cmd;
    case (f3)
      F3_ADD:  cmd = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  cmd = ALU_SLL;
      F3_SLT:  cmd = ALU_SLT;
      F3_SLTU: cmd = ALU_SLTU;
      F3_XOR:  cmd = ALU_XOR;
      F3_SR:   cmd = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   cmd = ALU_OR;
      default: cmd = ALU_AND;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of OP / OP-IMM / LUI / AUIPC into an ALU issue record.
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [ISSUE_XLEN-1:0] pc,
  input  logic [ISSUE_XLEN-1:0] rs1_data,
  input  logic [ISSUE_XLEN-1:0] rs2_data,
  output alu_issue_t            issue
);

  logic [6:0]            opcode;
  logic [6:0]            f7;
  logic [2:0]            f3;
  logic                  is_shift;
  logic [ISSUE_XLEN-1:0] imm_i;
  logic [ISSUE_XLEN-1:0] imm_u;
  logic [ISSUE_XLEN-1:0] shamt_imm;
  logic [ISSUE_XLEN-1:0] shamt_reg;

  assign opcode    = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign is_shift  = (f3 == F3_SLL) || (f3 == F3_SR);
  assign imm_i     = ISSUE_XLEN'($signed(instr[31:20]));
  assign imm_u     = ISSUE_XLEN'($signed({instr[31:12], 12'b0}));
  assign shamt_imm = ISSUE_XLEN'(instr[24:20]);
  assign shamt_reg = ISSUE_XLEN'(rs2_data[4:0]);

  always_comb begin
    issue         = '0;
    issue.cmd     = ALU_ADD;
    issue.rd      = instr[11:7];
    issue.illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
          issue.illegal = 1'b0;
          issue.cmd     = f3_cmd(f3, f7[5]);
          issue.a       = rs1_data;
          issue.b       = is_shift ? shamt_reg : rs2_data;
        end
      end
      OPC_OPIMM: begin
        // only shifts carry a funct7 field; f3=000 is always ADDI
        if (!is_shift || f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SR)) begin
          issue.illegal = 1'b0;
          issue.cmd     = f3_cmd(f3, is_shift & f7[5]);
          issue.a       = rs1_data;
          issue.b       = is_shift ? shamt_imm : imm_i;
        end
      end
      OPC_LUI: begin
        issue.illegal = 1'b0;
        issue.b       = imm_u;
      end
      OPC_AUIPC: begin
        issue.illegal = 1'b0;
        issue.a       = pc;
        issue.b       = imm_u;
      end
      default: ;
    endcase
    issue.we = !issue.illegal && (issue.rd != 5'd0);
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decode plus output register and one-entry skid buffer.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN issues illegal encodings flagged instead of dropping them.
module alu_op_issue
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output alu_cmd_t        out_cmd,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  alu_issue_t dec;
  alu_issue_t out_q, out_d;
  alu_issue_t skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       ready_q;
  logic       accept, drain, push;

  alu_op_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .issue    (dec)
  );

  assign accept = in_valid & ready_q;
  assign drain  = out_valid_q & out_ready;
  // without the trap option an illegal word is consumed but never enters storage
  assign push   = accept & (TRAP_EN | ~dec.illegal);

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!out_valid_q || out_ready) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = out_valid_q;
  assign out_cmd     = out_q.cmd;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_rd      = out_q.rd;
  assign out_we      = out_q.we;
  assign out_illegal = out_q.illegal & TRAP_EN;

endmodule
